// File: rtl/mux_logic_unit.sv
// Mux-only logic unit with a STAGES-deep result pipeline and an LFSR/MISR self-test controller.
// Every result bit is built from 2:1 selects; the controller reuses the same datapath for test vectors.
module mux_logic_unit #(
   parameter int WIDTH    = 8,
   parameter int STAGES   = 2,
   parameter int TEST_LEN = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             in_valid,
   input  logic             self_test,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic             busy,
   output logic             test_done,
   output logic [WIDTH-1:0] signature
);

   // state | meaning
   // IDLE  | external operands accepted, waiting for self_test
   // RUN   | one LFSR vector issued per cycle, TEST_LEN vectors
   // DRAIN | pipeline flushing for STAGES cycles, MISR still folding
   // DONE  | single-cycle test_done pulse, then back to IDLE

   localparam int          CW   = $clog2(TEST_LEN);
   localparam logic [15:0] SEED = 16'hACE1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t           state, state_nxt;
   logic [15:0]      lfsr;
   logic [CW-1:0]    cnt;
   logic [2:0]       drain_cnt;
   logic [WIDTH-1:0] sig;

   logic             iss_v;
   logic [2:0]       iss_op;
   logic [WIDTH-1:0] iss_a, iss_b, iss_res;

   logic [WIDTH-1:0] pd [STAGES];
   logic [STAGES-1:0] pv;

   logic             run_last;
   logic             lfsr_fb;

   function automatic logic [WIDTH-1:0] mux_eval(input logic [2:0] s,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
      logic [WIDTH-1:0] r;
      logic nx, f_and, f_or, f_xor, f_nand, f_nor, f_xnor, lo, hi;
      r = '0;
      for (int i = 0; i < WIDTH; i++) begin
         nx     = x[i] ? 1'b0 : 1'b1;
         f_and  = y[i] ? x[i] : 1'b0;
         f_or   = y[i] ? 1'b1 : x[i];
         f_xor  = y[i] ? nx   : x[i];
         f_nand = y[i] ? nx   : 1'b1;
         f_nor  = y[i] ? 1'b0 : nx;
         f_xnor = y[i] ? x[i] : nx;
         lo     = s[1] ? (s[0] ? f_nand : f_xor) : (s[0] ? f_or   : f_and);
         hi     = s[1] ? (s[0] ? y[i]   : nx)    : (s[0] ? f_xnor : f_nor);
         r[i]   = s[2] ? hi : lo;
      end
      return r;
   endfunction

   assign run_last = (cnt == CW'(TEST_LEN - 1));
   assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   always_comb begin
      iss_v  = 1'b0;
      iss_op = op;
      iss_a  = a;
      iss_b  = b;
      case (state)
         IDLE: iss_v = in_valid;
         RUN: begin
            iss_v  = 1'b1;
            iss_op = cnt[2:0];
            iss_a  = lfsr[WIDTH-1:0];
            iss_b  = lfsr[15:16-WIDTH];
         end
         default: iss_v = 1'b0;
      endcase
   end

   assign iss_res = mux_eval(iss_op, iss_a, iss_b);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (self_test) state_nxt = RUN;
         RUN:     if (run_last) state_nxt = DRAIN;
         DRAIN:   if (drain_cnt == 3'd0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         lfsr      <= SEED;
         cnt       <= '0;
         drain_cnt <= 3'd0;
         sig       <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (self_test) begin
                  lfsr <= SEED;
                  cnt  <= '0;
                  sig  <= '0;
               end
            end
            RUN: begin
               lfsr <= {lfsr[14:0], lfsr_fb};
               cnt  <= cnt + CW'(1);
               if (run_last) drain_cnt <= 3'(STAGES - 1);
            end
            DRAIN: drain_cnt <= drain_cnt - 3'd1;
            default: ;
         endcase
         // MISR folds whatever the pipeline presents while the test owns it
         if ((state == RUN || state == DRAIN) && out_valid)
            sig <= {sig[WIDTH-2:0], sig[WIDTH-1]} ^ out;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pv <= '0;
         for (int s = 0; s < STAGES; s++) pd[s] <= '0;
      end else begin
         pv[0] <= iss_v;
         if (iss_v) pd[0] <= iss_res;
         // data registers only load behind a valid so out holds across gaps
         for (int s = 1; s < STAGES; s++) begin
            pv[s] <= pv[s-1];
            if (pv[s-1]) pd[s] <= pd[s-1];
         end
      end
   end

   assign out       = pd[STAGES-1];
   assign out_valid = pv[STAGES-1];
   assign busy      = (state == RUN) || (state == DRAIN);
   assign test_done = (state == DONE);
   assign signature = sig;

endmodule
